// File: rtl/rgb_pkg.sv
// Shared types and constants for the UART-controlled RGB LED block:
// color and receiver state enums, ASCII command bytes and the decode helpers.
package rgb_pkg;

  typedef enum logic [2:0] {
    OFF,
    RED,
    GREEN,
    BLUE,
    YELLOW,
    CYAN,
    MAGENTA,
    WHITE
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] CMD_RED     = 8'h52;  // 'R'
  localparam logic [7:0] CMD_GREEN   = 8'h47;  // 'G'
  localparam logic [7:0] CMD_BLUE    = 8'h42;  // 'B'
  localparam logic [7:0] CMD_YELLOW  = 8'h59;  // 'Y'
  localparam logic [7:0] CMD_CYAN    = 8'h43;  // 'C'
  localparam logic [7:0] CMD_MAGENTA = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_WHITE   = 8'h57;  // 'W'
  localparam logic [7:0] CMD_OFF     = 8'h4B;  // 'K'

  // Unknown command bytes keep the current color.
  function automatic color_t decode_cmd(input logic [7:0] cmd, input color_t cur);
    color_t c;
    case (cmd)
      CMD_RED:     c = RED;
      CMD_GREEN:   c = GREEN;
      CMD_BLUE:    c = BLUE;
      CMD_YELLOW:  c = YELLOW;
      CMD_CYAN:    c = CYAN;
      CMD_MAGENTA: c = MAGENTA;
      CMD_WHITE:   c = WHITE;
      CMD_OFF:     c = OFF;
      default:     c = cur;
    endcase
    return c;
  endfunction

  // Returns {red, green, blue}, active-high.
  function automatic logic [2:0] color_rgb(input color_t c);
    logic [2:0] rgb;
    case (c)
      RED:     rgb = 3'b100;
      GREEN:   rgb = 3'b010;
      BLUE:    rgb = 3'b001;
      YELLOW:  rgb = 3'b110;
      CYAN:    rgb = 3'b011;
      MAGENTA: rgb = 3'b101;
      WHITE:   rgb = 3'b111;
      default: rgb = 3'b000;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART deserializer with a 2-flop input synchronizer; produces a
// one-cycle rx_valid for a good frame or frame_err for a low stop bit.
module uart_rx_core
  import rgb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW   = $clog2(CLKS_PER_BIT + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_t      state;
  logic [1:0]     sync;
  logic [TW-1:0]  timer;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           rx_sync;

  assign rx_sync = sync[1];

  // Start is re-checked mid-bit so short glitches return to IDLE; every later
  // sample lands a whole bit period after that mid-bit point.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state <= START;
            timer <= '0;
          end
        end
        START: begin
          if (timer == TW'(HALF - 1)) begin
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              state   <= DATA;
              timer   <= '0;
              bit_idx <= '0;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DATA: begin
          if (timer == TW'(CLKS_PER_BIT - 1)) begin
            timer <= '0;
            shift <= {rx_sync, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        STOP: begin
          if (timer == TW'(CLKS_PER_BIT - 1)) begin
            state <= IDLE;
            timer <= '0;
            if (rx_sync) begin
              rx_byte  <= shift;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rgb_cmd_rx.sv
// UART command receiver driving an active-low RGB LED from ASCII color bytes.
// Define RGB_CMD_TIMEOUT_EN to blank the LED after TIMEOUT idle clocks.
module rgb_cmd_rx
  import rgb_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int TIMEOUT  = 24000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       RGB_R,
  output logic       RGB_G,
  output logic       RGB_B,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  color_t color;
  color_t color_next;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

`ifdef RGB_CMD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idle_cnt;
  logic          timed_out;

  assign timed_out = (idle_cnt == CW'(TIMEOUT - 1));

  // Counter parks at TIMEOUT-1 so the blanking stays in force until a new byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (rx_valid) begin
      idle_cnt <= '0;
    end else if (!timed_out) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  always_comb begin
    color_next = color;
    if (rx_valid) begin
      color_next = decode_cmd(rx_byte, color);
    end else if (timed_out) begin
      color_next = OFF;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;

  always_comb begin
    color_next = color;
    if (rx_valid) begin
      color_next = decode_cmd(rx_byte, color);
    end
  end
`endif

  // Pins load from color_next so they move in the same edge as the register.
  always_ff @(posedge clk) begin
    if (rst) begin
      color                 <= OFF;
      {RGB_R, RGB_G, RGB_B} <= 3'b111;
    end else begin
      color                 <= color_next;
      {RGB_R, RGB_G, RGB_B} <= ~color_rgb(color_next);
    end
  end

endmodule

// File: tb/tb_rgb_cmd_rx.sv
// Directed scoreboard bench for rgb_cmd_rx: frames are queued as they are sent
// and checked when the DUT pulses rx_valid/frame_err.
module tb_rgb_cmd_rx;

  localparam int CPB = 12000000 / 115200;
  localparam int TMO = 1000;

  typedef struct {
    logic       err;
    logic [7:0] byte_v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       uart_rx;
  logic       RGB_R, RGB_G, RGB_B;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       frame_err;

  exp_t       exp_q[$];
  logic [2:0] model_rgb;
  logic [7:0] last_good;
  logic       pin_check;
  int         idle;
  int         n_asserts;
  int         n_fail;

  rgb_cmd_rx #(
    .CLK_FREQ(12000000),
    .BAUD    (115200),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .RGB_R    (RGB_R),
    .RGB_G    (RGB_G),
    .RGB_B    (RGB_B),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] ref_rgb(input logic [7:0] b, input logic [2:0] cur);
    case (b)
      8'h52:   return 3'b100;
      8'h47:   return 3'b010;
      8'h42:   return 3'b001;
      8'h59:   return 3'b110;
      8'h43:   return 3'b011;
      8'h4D:   return 3'b101;
      8'h57:   return 3'b111;
      8'h4B:   return 3'b000;
      default: return cur;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok);
    exp_t e;
    e.err    = ~stop_ok;
    e.byte_v = b;
    exp_q.push_back(e);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    if (stop_ok) begin
      uart_rx = 1'b1;
      wait_clks(CPB);
    end else begin
      uart_rx = 1'b0;
      wait_clks(70);
      uart_rx = 1'b1;
      wait_clks(CPB - 70);
    end
  endtask

  // Reference model and pulse scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    logic has;
    if (rst) begin
      pin_check = 1'b0;
    end else begin
`ifdef RGB_CMD_TIMEOUT_EN
      if (rx_valid) idle = 0;
      else if (idle < TMO + 1) idle++;
      if (idle >= TMO + 1) model_rgb = 3'b000;
`endif
      if (pin_check) begin
        check_output("rgb_pins", {29'd0, RGB_R, RGB_G, RGB_B}, {29'd0, ~model_rgb});
        pin_check = 1'b0;
      end
      if (rx_valid || frame_err) begin
        has = (exp_q.size() > 0);
        check_output("frame_expected", {31'd0, has}, 32'd1);
        if (has) begin
          e = exp_q.pop_front();
          check_output("pulse_kind", {30'd0, rx_valid, frame_err}, {30'd0, ~e.err, e.err});
          if (!e.err) begin
            last_good = e.byte_v;
            model_rgb = ref_rgb(e.byte_v, model_rgb);
          end
          check_output("rx_byte", {24'd0, rx_byte}, {24'd0, last_good});
          pin_check = 1'b1;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] partial;
    n_asserts = 0;
    n_fail    = 0;
    model_rgb = 3'b000;
    last_good = 8'h00;
    pin_check = 1'b0;
    idle      = 0;
    uart_rx   = 1'b1;
    rst       = 1'b1;

    wait_clks(5);
    @(negedge clk);
    check_output("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("reset_rx_byte", {24'd0, rx_byte}, 32'h00);
    check_output("reset_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clks(200);
    check_output("idle_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);

    send_frame(8'h59, 1'b1);
    wait_clks(300);

    send_frame(8'h43, 1'b1);
    send_frame(8'h4B, 1'b1);
    wait_clks(300);

    send_frame(8'h43, 1'b1);
    wait_clks(300);
    send_frame(8'h52, 1'b0);
    wait_clks(300);

    uart_rx = 1'b0;
    wait_clks(30);
    uart_rx = 1'b1;
    wait_clks(300);
    send_frame(8'h78, 1'b1);
    wait_clks(300);

    send_frame(8'h47, 1'b1);
`ifdef RGB_CMD_TIMEOUT_EN
    wait_clks(TMO + 20);
    check_output("timeout_off", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
`else
    wait_clks(1500);
    check_output("color_held", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h5);
`endif

    partial = 8'h42;
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = partial[i];
      wait_clks(CPB);
    end
    rst       = 1'b1;
    model_rgb = 3'b000;
    last_good = 8'h00;
    idle      = 0;
    wait_clks(3);
    @(negedge clk);
    check_output("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_output("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check_output("midreset_rx_byte", {24'd0, rx_byte}, 32'h00);
    check_output("midreset_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h7);
    uart_rx = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_clks(200);

    send_frame(8'h42, 1'b1);
    wait_clks(300);
    check_output("blue_pins", {29'd0, RGB_R, RGB_G, RGB_B}, 32'h6);
    check_output("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_cmd_rx.md
RGB_CMD_RX -- requirements
Module: rgb_cmd_rx

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, integer division (104 at defaults).
REQ-003 Parameter TIMEOUT, default 24000000, idle-blank interval in clocks (used only with RGB_CMD_TIMEOUT_EN).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 uart_rx  input  1  asynchronous UART line, 8N1, idle high.
REQ-007 RGB_R  output  1  red LED drive, active-low.
REQ-008 RGB_G  output  1  green LED drive, active-low.
REQ-009 RGB_B  output  1  blue LED drive, active-low.
REQ-010 rx_valid  output  1  one-cycle pulse, good byte received.
REQ-011 rx_byte  output  8  last received byte; stable until next rx_valid.
REQ-012 frame_err  output  1  one-cycle pulse, stop bit sampled low.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-014 Receiver FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE: synchronized line low -> START, clear bit-timer.
REQ-016 START: at CLKS_PER_BIT/2 clocks, line high -> IDLE (false start, no pulse); line low -> DATA, clear timer and bit index.
REQ-017 DATA: sample every CLKS_PER_BIT clocks, LSB first; after 8th sample -> STOP.
REQ-018 STOP: after CLKS_PER_BIT clocks, sample line: high -> rx_byte updated, rx_valid pulse; low -> frame_err pulse, rx_byte unchanged; either case -> IDLE in same cycle.
REQ-019 Back-to-back frames with zero idle time SHALL be received without loss.
REQ-020 Color decode (uppercase ASCII only): 'R' red, 'G' green, 'B' blue, 'Y' red+green, 'C' green+blue, 'M' red+blue, 'W' all, 'K' all off.
REQ-021 Color register SHALL update on the clock after rx_valid; RGB pins registered, so pins change one cycle after rx_valid.
REQ-022 Unrecognized bytes and frame errors SHALL leave the color unchanged.
REQ-023 rx_valid and frame_err SHALL never assert in the same cycle.

Reset
REQ-024 While rst high: FSM IDLE, timers/index 0, synchronizer 1, rx_byte 0x00, rx_valid 0, frame_err 0, RGB_R/G/B = 1 (off).
REQ-025 Reset mid-frame SHALL abandon the frame with no pulse; the next falling edge after reset starts a new frame.

Configuration
REQ-026 Macro RGB_CMD_TIMEOUT_EN defined: counter cleared by every rx_valid; on reaching TIMEOUT-1 without rx_valid the color register SHALL go to off and the counter holds until next rx_valid.
REQ-027 Macro RGB_CMD_TIMEOUT_EN undefined: no counter; color held indefinitely; TIMEOUT unused.

Structure
REQ-028 Package rgb_pkg SHALL hold the color enum (OFF, RED, GREEN, BLUE, YELLOW, CYAN, MAGENTA, WHITE), the receiver state enum, and the ASCII command constants.
REQ-029 UART deserializer (REQ-013..REQ-019, REQ-023) SHALL be sub-module uart_rx_core; rgb_cmd_rx instantiates it and adds decode, color register and timeout.

Verification
REQ-030 Reset, line idle 1 -> RGB_R/G/B = 1/1/1, rx_valid never pulses.
REQ-031 Send 'Y' (0x59) at 104 clk/bit -> rx_valid pulse, rx_byte 0x59, next cycle RGB_R/G/B = 0/0/1.
REQ-032 Send 'C' then 'K' back-to-back, no idle -> two rx_valid pulses; RGB 1/0/0 then 1/1/1.
REQ-033 Send 'R' with stop bit forced low -> frame_err pulse, no rx_valid, color unchanged.
REQ-034 30-clock low glitch on idle line -> no pulse, FSM back in IDLE; then 'x' (0x78) -> rx_valid, rx_byte 0x78, color unchanged.
REQ-035 With RGB_CMD_TIMEOUT_EN, TIMEOUT=1000: send 'G', idle 1000 clocks -> RGB returns to 1/1/1; assert rst mid-byte -> no pulses, outputs at reset values.
